seq_hit_counter_display: RTL and testbench
==========================================

SEQ_HIT_COUNTER_DISPLAY -- requirements
Module: seq_hit_counter_display

Interface
REQ-001 The block SHALL have parameter STRETCH_CYCLES, default 24'd1000000, which sets the decimal-point stretch length in clk cycles (legal range 1..2^24-1).
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n: reset rst_n, asynchronous, active-high; clock clk.
REQ-004 The block SHALL have port hit_in, input, 1 bit: detection level from the upstream sequence detector, synchronous to clk.
REQ-005 The block SHALL have port ena, input, 1 bit: count enable; hits are ignored while low.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of count, sticky overflow flag and stretch timer.
REQ-007 The block SHALL have port seg_out, output, 8 bits: [6:0] segments a..g and [7] the decimal point, all active-high and registered.
REQ-008 The block SHALL have port count_out, output, 4 bits: the current BCD count, registered.
REQ-009 The block SHALL have port ovf_pulse, output, 1 bit: one-cycle pulse when the count wraps 9->0.
REQ-010 The block SHALL have port ovf_sticky, output, 1 bit: set on wrap, held until clr or reset.

Function
REQ-011 The block SHALL register hit_in into hit_q every cycle, regardless of ena, and SHALL define the event hit_rise = hit_in & ~hit_q.
REQ-012 On a cycle where hit_rise=1, ena=1 and clr=0, count_out SHALL increment by 1 at the next edge, with no other delay.
REQ-013 A count increment from 9 SHALL yield 0, assert ovf_pulse for exactly that one cycle, and set ovf_sticky.
REQ-014 clr=1 SHALL take priority over a simultaneous hit_rise: count_out, ovf_sticky, ovf_pulse and the stretch timer all go to 0 at the next edge.
REQ-015 A hit level held high SHALL count once only, and deasserting then reasserting ena during a held level SHALL NOT count again.
REQ-016 seg_out[6:0] SHALL be the registered decode of the post-update count, one cycle after count_out: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-017 The count SHALL never leave 0..9, so no undefined decode codes are needed.
REQ-018 seg_out[7] SHALL follow the HIT_STRETCH_EN rules in the Configuration section.

Reset
REQ-019 While rst_n=1, the block SHALL asynchronously force the following values: hit_q=0, count_out=0, ovf_pulse=0, ovf_sticky=0, stretch timer=0, seg_out=8'h3F.
REQ-020 Reset asserted mid-stretch or mid-increment SHALL abort the operation with no residual pulse after release.
REQ-021 After reset release, a hit_in already high on the first edge SHALL count, because hit_q resets to 0.

Configuration
REQ-022 The block SHALL support the macro HIT_STRETCH_EN.
REQ-023 With HIT_STRETCH_EN defined, each counted hit_rise SHALL load a 24-bit down-counter with STRETCH_CYCLES, and seg_out[7]=1 while the counter is nonzero.
REQ-024 With HIT_STRETCH_EN defined, a new counted hit during an active stretch SHALL reload the counter (retrigger), and clr SHALL zero it.
REQ-025 With HIT_STRETCH_EN undefined, no timer SHALL exist and seg_out[7] SHALL equal hit_q, the one-cycle-delayed hit_in level, ignoring ena.

Verification
REQ-026 The bench SHALL cover: reset, then three single-cycle hit_in pulses spaced 4 cycles apart with ena=1 -> count_out 1,2,3 each one cycle after the pulse, and seg_out[6:0]=06,5B,4F one cycle after that.
REQ-027 The bench SHALL cover: ten counted hits from 0 -> count_out=0 after the 10th hit, ovf_pulse high exactly 1 cycle, ovf_sticky=1, seg_out=3F (dp excluded).
REQ-028 The bench SHALL cover: hit_in held high for 20 cycles with ena toggled at cycle 5 and cycle 10 -> count increments exactly once.
REQ-029 The bench SHALL cover: hit_rise and clr in the same cycle at count=7 -> count_out=0, ovf_sticky=0, no dp stretch.
REQ-030 The bench SHALL cover, with HIT_STRETCH_EN and STRETCH_CYCLES=8: hit at t0 and a second hit at t0+5 -> seg_out[7] high continuously until 8 cycles after the second load, then low.
REQ-031 The bench SHALL cover: rst_n asserted mid-stretch at count=4, asynchronously between clock edges -> outputs reach reset values before the next edge, and no ovf_pulse occurs.

Source files
------------

// File: rtl/seq_hit_counter_display.sv
// seq_hit_counter_display
//   Counts rising edges of a sequence-detector hit level as a BCD digit
//   (0..9, wrapping) and drives a registered 7-segment display of the count.
//
//   Optional feature macro: HIT_STRETCH_EN
//     defined   : each counted hit (re)loads a 24-bit down-counter with
//                 STRETCH_CYCLES; the decimal point is lit while it is nonzero.
//     undefined : no timer; the decimal point mirrors hit_q (hit_in delayed
//                 one cycle, independent of ena).
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous reset, active HIGH (legacy name)
//   hit_in     : hit level from upstream detector, synchronous to clk
//   ena        : count enable
//   clr        : synchronous clear of count, sticky flag, pulse and timer
//   seg_out    : [6:0] segments a..g, [7] decimal point, active high
//   count_out  : current BCD count
//   ovf_pulse  : one-cycle pulse on a 9->0 wrap
//   ovf_sticky : set on wrap, held until clr or reset
module seq_hit_counter_display #(
  parameter logic [23:0] STRETCH_CYCLES = 24'd1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit_in,
  input  logic       ena,
  input  logic       clr,
  output logic [7:0] seg_out,
  output logic [3:0] count_out,
  output logic       ovf_pulse,
  output logic       ovf_sticky
);

  logic       hit_q;
  logic       hit_rise;
  logic       cnt_evt;
  logic       wrap;
  logic [3:0] count_nxt;
  logic [6:0] seg_dec;
  logic [6:0] seg_lo;
  logic       dp;

  assign hit_rise  = hit_in & ~hit_q;
  // clr wins over a coincident edge, so the event is gated here once.
  assign cnt_evt   = hit_rise & ena & ~clr;
  assign wrap      = cnt_evt & (count_out == 4'd9);
  assign count_nxt = wrap ? 4'd0 : count_out + 4'd1;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hit_q      <= 1'b0;
      count_out  <= 4'd0;
      ovf_pulse  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      hit_q     <= hit_in;
      ovf_pulse <= wrap;
      if (clr) begin
        count_out  <= 4'd0;
        ovf_sticky <= 1'b0;
      end else if (cnt_evt) begin
        count_out <= count_nxt;
        if (wrap) ovf_sticky <= 1'b1;
      end
    end
  end

  // Decode of the registered count; the segment register therefore lags
  // count_out by one cycle.
  always_comb begin
    seg_dec = 7'h00;
    case (count_out)
      4'd0: seg_dec = 7'h3F;
      4'd1: seg_dec = 7'h06;
      4'd2: seg_dec = 7'h5B;
      4'd3: seg_dec = 7'h4F;
      4'd4: seg_dec = 7'h66;
      4'd5: seg_dec = 7'h6D;
      4'd6: seg_dec = 7'h7D;
      4'd7: seg_dec = 7'h07;
      4'd8: seg_dec = 7'h7F;
      4'd9: seg_dec = 7'h6F;
      default: seg_dec = 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) seg_lo <= 7'h3F;
    else       seg_lo <= seg_dec;
  end

`ifdef HIT_STRETCH_EN
  logic [23:0] stretch_cnt;

  // Reload on every counted hit gives retrigger behaviour for free.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                    stretch_cnt <= 24'd0;
    else if (clr)                 stretch_cnt <= 24'd0;
    else if (cnt_evt)             stretch_cnt <= STRETCH_CYCLES;
    else if (stretch_cnt != 24'd0) stretch_cnt <= stretch_cnt - 24'd1;
  end

  assign dp = (stretch_cnt != 24'd0);
`else
  assign dp = hit_q;
`endif

  assign seg_out = {dp, seg_lo};

endmodule

// File: tb/tb_seq_hit_counter_display.sv
// Testbench for seq_hit_counter_display: directed scenarios plus random
// traffic, checked by a scoreboard against a cycle-level reference model.
// Works with or without HIT_STRETCH_EN defined.
module tb_seq_hit_counter_display;

  localparam int STRETCH = 8;

  logic       clk;
  logic       rst_n;
  logic       hit_in;
  logic       ena;
  logic       clr;
  logic [7:0] seg_out;
  logic [3:0] count_out;
  logic       ovf_pulse;
  logic       ovf_sticky;

  seq_hit_counter_display #(.STRETCH_CYCLES(24'(STRETCH))) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hit_in    (hit_in),
    .ena       (ena),
    .clr       (clr),
    .seg_out   (seg_out),
    .count_out (count_out),
    .ovf_pulse (ovf_pulse),
    .ovf_sticky(ovf_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] cnt;
    logic [7:0] seg;
    logic       pulse;
    logic       sticky;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [6:0] seg_tbl [10];

  // Reference model state: digit as plain integer, seg as table lookup of
  // the digit shown one cycle earlier.
  int         m_cnt;
  logic       m_sticky;
  logic       m_pulse;
  logic       m_hitq;
  logic [6:0] m_seg;
  int         m_cyc;
`ifdef HIT_STRETCH_EN
  int         m_load;
`endif

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sticky = 0; m_pulse = 0; m_hitq = 0; m_seg = 7'h3F;
`ifdef HIT_STRETCH_EN
    m_load = -100000;
`endif
  endtask

  function automatic logic model_dp();
`ifdef HIT_STRETCH_EN
    return (m_cyc - m_load) < STRETCH;
`else
    return m_hitq;
`endif
  endfunction

  task automatic model_edge(input logic h, input logic e, input logic c, input logic r);
    logic rise;
    m_cyc++;
    if (r) begin
      model_reset();
      return;
    end
    rise  = h && !m_hitq;
    m_seg = seg_tbl[m_cnt];
    m_pulse = 1'b0;
    if (c) begin
      m_cnt = 0; m_sticky = 0;
`ifdef HIT_STRETCH_EN
      m_load = -100000;
`endif
    end else if (rise && e) begin
      if (m_cnt == 9) begin m_pulse = 1'b1; m_sticky = 1'b1; end
      m_cnt = (m_cnt + 1) % 10;
`ifdef HIT_STRETCH_EN
      m_load = m_cyc;
`endif
    end
    m_hitq = h;
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.cnt    = 4'(m_cnt);
    x.seg    = {model_dp(), m_seg};
    x.pulse  = m_pulse;
    x.sticky = m_sticky;
    return x;
  endfunction

  // Drive inputs, let the edge happen, push what the DUT must show after it.
  task automatic step(input logic h, input logic e, input logic c, input logic r);
    hit_in = h; ena = e; clr = c; rst_n = r;
    @(posedge clk);
    model_edge(h, e, c, r);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic pulse_hit(input int gap);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < gap; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: every settled cycle compares DUT outputs with the oldest entry.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("count_out",  int'(count_out),  int'(e.cnt));
      chk("seg_out",    int'(seg_out),    int'(e.seg));
      chk("ovf_pulse",  int'(ovf_pulse),  int'(e.pulse));
      chk("ovf_sticky", int'(ovf_sticky), int'(e.sticky));
    end
  end

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    m_cyc = 0;
    model_reset();
    hit_in = 0; ena = 0; clr = 0; rst_n = 0;
    #1 rst_n = 1;
    #1;
    // Async reset takes effect before any clock edge.
    chk("rst_count", int'(count_out),  0);
    chk("rst_seg",   int'(seg_out),    'h3F);
    chk("rst_pulse", int'(ovf_pulse),  0);
    chk("rst_sticky",int'(ovf_sticky), 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);

    // Three pulses spaced 4 cycles apart.
    for (int i = 0; i < 3; i++) pulse_hit(3);

    // Ten counted hits from 0: wrap, one-cycle pulse, sticky set.
    step(0, 1, 1, 0);
    for (int i = 0; i < 10; i++) pulse_hit(1);
    pulse_hit(3);

    // Held level with ena toggled: counts exactly once.
    step(0, 1, 1, 0);
    for (int i = 0; i < 20; i++) step(1, !(i >= 5 && i < 10), 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);

    // clr coincident with a hit edge at count 7.
    step(0, 1, 1, 0);
    for (int i = 0; i < 7; i++) pulse_hit(1);
    step(1, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

    // Stretch retrigger: hits 5 cycles apart, dp watched for 14 more cycles.
    pulse_hit(4);
    pulse_hit(14);

    // Async reset mid-stretch at count 4.
    step(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) pulse_hit(1);
    #2 rst_n = 1;
    #1;
    exp_q.delete();
    model_reset();
    chk("arst_count", int'(count_out),  0);
    chk("arst_seg",   int'(seg_out),    'h3F);
    chk("arst_pulse", int'(ovf_pulse),  0);
    chk("arst_sticky",int'(ovf_sticky), 0);
    step(1, 1, 0, 1);
    // hit_in already high at release must count.
    step(1, 1, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 7) != 0),
           logic'($urandom_range(0, 39) == 0), 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
